gpr_file: RTL and testbench

- Integer general-purpose register file for the single-cycle RV32 core.
- 2^ADDR_WIDTH entries of DATA_WIDTH bits each.
- One synchronous write port and two combinational read ports (rs1/rs2); entry 0 is hardwired to zero.
- Sits between the decode unit (supplies rs1/rs2/rd) and the execute unit (consumes the read data and returns the ALU result as write data).

---
 rtl/gpr_file_pkg.sv | 15 +
 rtl/gpr_file_reset_reg.sv | 40 ++++
 rtl/gpr_file.sv | 70 +++++++
 tb/tb_gpr_file.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/gpr_file_pkg.sv
// Shared definitions for the integer register file and its storage cell.
//   GPR_ADDR_W   : register index width (32 entries)
//   GPR_DATA_W   : register width in bits
//   GPR_ZERO_IDX : index of the hardwired-zero entry (x0)
//   gpr_addr_t / gpr_data_t : index and data types at the default sizes
package gpr_file_pkg;

   localparam int unsigned GPR_ADDR_W   = 5;
   localparam int unsigned GPR_DATA_W   = 32;
   localparam int unsigned GPR_ZERO_IDX = 0;

   typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;
   typedef logic [GPR_DATA_W-1:0] gpr_data_t;

endpackage

// File: rtl/gpr_file_reset_reg.sv
// reset_reg: generic enabled flop with an asynchronous active-low reset.
// One instance holds each writable register-file entry; the same cell is
// also used for the core PC (WIDTH=32, RESET_VAL=32'h8000_0000, wen=1).
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, loads RESET_VAL
//   wen   : load din on the next rising edge
//   din   : next value
//   dout  : stored value
module reset_reg #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wen,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] dout_d;
   logic [WIDTH-1:0] dout_q;

   always_comb begin
      dout_d = dout_q;
      if (wen) begin
         dout_d = din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout_q <= RESET_VAL;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/gpr_file.sv
// gpr_file: RV32 integer register file, 2^ADDR_WIDTH x DATA_WIDTH.
// One synchronous write port, two combinational read ports; entry 0 reads 0.
//   clk            : rising-edge clock
//   reset          : asynchronous active-low reset; writable entries -> RESET_VAL
//   wen/waddr/wdata: write port (rd); writes to index 0 are dropped
//   raddr1/rdata1  : read port 1 (rs1)
//   raddr2/rdata2  : read port 2 (rs2)
// Build option: GPR_WRITE_BYPASS_EN forwards wdata to a read port that
// addresses the entry being written in the same cycle.
module gpr_file
   import gpr_file_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = GPR_ADDR_W,
   parameter int unsigned           DATA_WIDTH = GPR_DATA_W,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wen,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   output logic [DATA_WIDTH-1:0] rdata1,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   output logic [DATA_WIDTH-1:0] rdata2
);

   localparam int unsigned NUM_ENTRIES = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(GPR_ZERO_IDX);

   logic [DATA_WIDTH-1:0] entry [NUM_ENTRIES];

   // x0 has no storage; it is a constant zero.
   assign entry[0] = '0;

   for (genvar i = 1; i < NUM_ENTRIES; i++) begin : g_entry
      logic entry_wen;
      assign entry_wen = wen && (waddr == ADDR_WIDTH'(i));

      reset_reg #(
         .WIDTH     (DATA_WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_reg (
         .clk   (clk),
         .reset (reset),
         .wen   (entry_wen),
         .din   (wdata),
         .dout  (entry[i])
      );
   end

`ifdef GPR_WRITE_BYPASS_EN
   logic fwd_valid;
   assign fwd_valid = wen && reset && (waddr != ZERO_IDX);
`endif

   always_comb begin
      rdata1 = (raddr1 == ZERO_IDX) ? '0 : entry[raddr1];
      rdata2 = (raddr2 == ZERO_IDX) ? '0 : entry[raddr2];
`ifdef GPR_WRITE_BYPASS_EN
      if (fwd_valid && (raddr1 == waddr)) begin
         rdata1 = wdata;
      end
      if (fwd_valid && (raddr2 == waddr)) begin
         rdata2 = wdata;
      end
`endif
   end

endmodule

// File: tb/tb_gpr_file.sv
module tb_gpr_file;

   logic        clk;
   logic        rst_n;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;

   int pass_cnt  = 0;
   int check_cnt = 0;

   gpr_file dut (
      .clk    (clk),
      .reset  (rst_n),
      .wen    (wen),
      .waddr  (waddr),
      .wdata  (wdata),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .raddr2 (raddr2),
      .rdata2 (rdata2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      wen   = 1'b1;
      waddr = a;
      wdata = d;
      @(posedge clk);
      #1;
      wen = 1'b0;
   endtask

   logic [31:0] sum;

   initial begin
      rst_n  = 1'b0;
      wen    = 1'b0;
      waddr  = '0;
      wdata  = '0;
      raddr1 = '0;
      raddr2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_state_r1", rdata1, 32'h0);

      // Load something, then pulse reset mid-cycle and see it clear at once.
      write_reg(5'd4, 32'h0000_1234);
      @(negedge clk);
      raddr1 = 5'd4;
      #1;
      check("pre_reset_val", rdata1, 32'h0000_1234);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset_clear", rdata1, 32'h0);
      for (int i = 0; i < 32; i++) begin
         raddr1 = i[4:0];
         raddr2 = 5'(31 - i);
         #1;
         check($sformatf("reset_r1_%0d", i), rdata1, 32'h0);
         check($sformatf("reset_r2_%0d", 31 - i), rdata2, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Basic write/read and persistence.
      write_reg(5'd5, 32'h0000_0011);
      raddr1 = 5'd5;
      #1;
      check("write5_read", rdata1, 32'h0000_0011);
      @(negedge clk);
      waddr = 5'd5;
      wdata = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #1;
      check("wen0_persist", rdata1, 32'h0000_0011);

      // x0 immutability.
      write_reg(5'd0, 32'hDEAD_BEEF);
      raddr1 = 5'd0;
      raddr2 = 5'd0;
      #1;
      check("x0_r1", rdata1, 32'h0);
      check("x0_r2", rdata2, 32'h0);

      // Dual read and addi-style wrap-around.
      write_reg(5'd1, 32'h7FFF_FFFF);
      write_reg(5'd2, 32'h0000_0001);
      raddr1 = 5'd1;
      raddr2 = 5'd2;
      #1;
      check("dual_r1", rdata1, 32'h7FFF_FFFF);
      check("dual_r2", rdata2, 32'h0000_0001);
      sum = rdata1 + 32'hFFFF_FFFF;
      write_reg(5'd3, sum);
      raddr1 = 5'd3;
      raddr2 = 5'd3;
      #1;
      check("addi_wrap_r1", rdata1, 32'h7FFF_FFFE);
      check("same_entry_r2", rdata2, 32'h7FFF_FFFE);

      // Read-during-write.
      write_reg(5'd7, 32'h0000_000A);
      @(negedge clk);
      raddr1 = 5'd7;
      wen    = 1'b1;
      waddr  = 5'd7;
      wdata  = 32'h0000_000B;
      #1;
`ifdef GPR_WRITE_BYPASS_EN
      check("rdw_before_edge", rdata1, 32'h0000_000B);
`else
      check("rdw_before_edge", rdata1, 32'h0000_000A);
`endif
      @(posedge clk);
      #1;
      wen = 1'b0;
      check("rdw_after_edge", rdata1, 32'h0000_000B);

      // Reset asserted while a write is pending: reset wins.
      write_reg(5'd9, 32'h0000_0055);
      @(negedge clk);
      raddr1 = 5'd9;
      wen    = 1'b1;
      waddr  = 5'd9;
      wdata  = 32'h0000_00AA;
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_during_write", rdata1, 32'h0);
      @(negedge clk);
      wen   = 1'b0;
      rst_n = 1'b1;
      #1;
      check("rst_write_lost", rdata1, 32'h0);
      check("rst_other_entry", rdata2, 32'h0);

      // First edge after release accepts a write.
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      wen   = 1'b1;
      waddr = 5'd9;
      wdata = 32'h0000_0077;
      @(posedge clk);
      #1;
      wen = 1'b0;
      check("first_write_after_release", rdata1, 32'h0000_0077);
      raddr2 = 5'd31;
      #1;
      check("untouched_entry31", rdata2, 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
